// File: rtl/ieee1687_pkg.sv
// Shared IR codes, TDR field layout and the update-decode helper for the
// IJTAG instrument-access segment.
package ieee1687_pkg;

  localparam int IR_W   = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int STAT_W = 8;
  localparam int PAD_W  = 4;
  localparam int TDR_L  = ADDR_W + DATA_W + PAD_W;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 4;
  localparam int PAD_MSB  = 3;
  localparam int PAD_LSB  = 0;

  typedef enum logic [IR_W-1:0] {
    IR_BYPASS       = 4'h0,
    IR_IDCODE       = 4'h1,
    IR_IJTAG_ACCESS = 4'h8
  } ir_e;

  typedef struct packed {
    logic              enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } instr_req_t;

  // Takes the non-padding part of the TDR; address 0 means "no instrument".
  function automatic instr_req_t decode_fields(input logic [TDR_L-PAD_W-1:0] f);
    instr_req_t req;
    req.addr   = f[ADDR_MSB-PAD_W:ADDR_LSB-PAD_W];
    req.data   = f[DATA_MSB-PAD_W:DATA_LSB-PAD_W];
    req.enable = |f[ADDR_MSB-PAD_W:ADDR_LSB-PAD_W];
    return req;
  endfunction

endpackage

// File: rtl/ieee1687_ijtag_tdr.sv
// Generic capture/shift/update test data register with parallel-in and a
// shadow output register; all activity is gated by the select input.
module ijtag_tdr #(
  parameter int L    = 16,
  parameter int SH_W = 13
) (
  input  logic            tck,
  input  logic            trst_n,
  input  logic            sel,
  input  logic            capture,
  input  logic            shift,
  input  logic            update,
  input  logic            tdi,
  input  logic [L-1:0]    pdata,
  input  logic [SH_W-1:0] shadow_d,
  output logic [L-1:0]    sr,
  output logic [SH_W-1:0] shadow
);

  // Capture beats shift beats update; a deselected register holds everything.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      sr     <= {L{1'b0}};
      shadow <= {SH_W{1'b0}};
    end else if (sel) begin
      if (capture) begin
        sr <= pdata;
      end else if (shift) begin
        sr <= {tdi, sr[L-1:1]};
      end else if (update) begin
        shadow <= shadow_d;
      end else begin
        sr <= sr;
      end
    end else begin
      sr <= sr;
    end
  end

endmodule

// File: rtl/ieee1687_network.sv
// IJTAG instrument-access segment: IR decode, TDR field slicing, instrument
// enable generation and tdo gating around a generic TDR.
module ieee1687_network
  import ieee1687_pkg::*;
(
  input  logic              tck,
  input  logic              trst_n,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  input  logic              capture_dr,
  input  logic              shift_dr,
  input  logic              update_dr,
  input  logic [IR_W-1:0]   ir,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_enable,
  input  logic [STAT_W-1:0] instr_status
);

  logic             sel_s;
  logic [TDR_L-1:0] sr_s;
  logic [TDR_L-1:0] pdata_s;
  instr_req_t       req_d_s;
  instr_req_t       req_r;
  logic             unused_s;

  assign sel_s   = (ir == IR_IJTAG_ACCESS);
  assign pdata_s = {{(TDR_L-STAT_W){1'b0}}, instr_status};
  assign req_d_s = decode_fields(sr_s[TDR_L-1:PAD_W]);

  ijtag_tdr #(
    .L    (TDR_L),
    .SH_W ($bits(instr_req_t))
  ) u_tdr (
    .tck      (tck),
    .trst_n   (trst_n),
    .sel      (sel_s),
    .capture  (capture_dr),
    .shift    (shift_dr),
    .update   (update_dr),
    .tdi      (tdi),
    .pdata    (pdata_s),
    .shadow_d (req_d_s),
    .sr       (sr_s),
    .shadow   (req_r)
  );

  // Padding bits only matter as they pass through sr[0]; tms is decoded upstream.
  assign unused_s = ^{tms, sr_s[PAD_MSB:PAD_LSB]};

  assign tdo          = sel_s ? sr_s[0] : 1'b0;
  assign instr_addr   = req_r.addr;
  assign instr_data   = req_r.data;
  assign instr_enable = req_r.enable;

endmodule

// File: tb/tb_ieee1687_network.sv
// Directed self-checking bench for ieee1687_network: write, readback, sweep,
// deselect, strobe priority and asynchronous reset.
module tb_ieee1687_network;

  logic       tck = 1'b0;
  logic       trst_n;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic [3:0] ir;
  logic [7:0] instr_data;
  logic [3:0] instr_addr;
  logic       instr_enable;
  logic [7:0] instr_status;

  int n_checks = 0;
  int n_pass   = 0;

  ieee1687_network dut (
    .tck          (tck),
    .trst_n       (trst_n),
    .tms          (tms),
    .tdi          (tdi),
    .tdo          (tdo),
    .capture_dr   (capture_dr),
    .shift_dr     (shift_dr),
    .update_dr    (update_dr),
    .ir           (ir),
    .instr_data   (instr_data),
    .instr_addr   (instr_addr),
    .instr_enable (instr_enable),
    .instr_status (instr_status)
  );

  always #5 tck = ~tck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic do_capture();
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic do_update();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  // Shifts w in LSB-first while collecting the bits seen on tdo before each edge.
  task automatic shift_word(input logic [15:0] w, output logic [15:0] seen);
    seen = 16'h0000;
    shift_dr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      seen[i] = tdo;
      tdi = w[i];
      tick();
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] w);
    logic [15:0] dummy;
    shift_word(w, dummy);
    do_update();
  endtask

  logic [15:0] seen;
  logic [15:0] sweep_w [4] = '{16'h25A0, 16'h433F, 16'h8CC5, 16'h0770};
  logic [3:0]  sweep_a [4] = '{4'h2, 4'h4, 4'h8, 4'h0};
  logic [7:0]  sweep_d [4] = '{8'h5A, 8'h33, 8'hCC, 8'h77};
  logic        sweep_e [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    trst_n = 1'b0; tms = 1'b0; tdi = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    ir = 4'h8; instr_status = 8'h00;
    #12;
    check_eq("rst_addr", 32'(instr_addr), 32'h0);
    check_eq("rst_data", 32'(instr_data), 32'h0);
    check_eq("rst_en", 32'(instr_enable), 32'h0);
    check_eq("rst_tdo", 32'(tdo), 32'h0);
    #10 trst_n = 1'b1;
    tick();

    // Write 1A50 -> addr 1, data A5
    do_capture();
    write_word(16'h1A50);
    check_eq("wr_addr", 32'(instr_addr), 32'h1);
    check_eq("wr_data", 32'(instr_data), 32'hA5);
    check_eq("wr_en", 32'(instr_enable), 32'h1);

    // Readback of status 5A
    instr_status = 8'h5A;
    do_capture();
    check_eq("rb_tdo0", 32'(tdo), 32'h0);
    shift_word(16'h0000, seen);
    check_eq("rb_word", 32'(seen), 32'h005A);
    check_eq("rb_hold_data", 32'(instr_data), 32'hA5);

    for (int i = 0; i < 4; i++) begin
      write_word(sweep_w[i]);
      check_eq($sformatf("sw%0d_addr", i), 32'(instr_addr), 32'(sweep_a[i]));
      check_eq($sformatf("sw%0d_data", i), 32'(instr_data), 32'(sweep_d[i]));
      check_eq($sformatf("sw%0d_en", i), 32'(instr_enable), 32'(sweep_e[i]));
    end

    // Deselect: sr holds BEEF, outputs hold 0/77/0
    shift_word(16'hBEEF, seen);
    ir = 4'h0;
    capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1; tdi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("desel_tdo%0d", i), 32'(tdo), 32'h0);
    end
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
    check_eq("desel_data", 32'(instr_data), 32'h77);
    check_eq("desel_en", 32'(instr_enable), 32'h0);
    ir = 4'h8;
    #1;
    check_eq("resel_tdo", 32'(tdo), 32'h1);
    shift_word(16'h0000, seen);
    check_eq("desel_sr", 32'(seen), 32'hBEEF);

    // Capture beats shift (sr is 0, so a shift would give tdo=0)
    instr_status = 8'hC3;
    capture_dr = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
    tick();
    capture_dr = 1'b0; shift_dr = 1'b0; tdi = 1'b0;
    check_eq("prio_tdo", 32'(tdo), 32'h1);
    shift_word(16'h0000, seen);
    check_eq("prio_sr", 32'(seen), 32'h00C3);

    // Async reset mid-shift
    write_word(16'h3C3F);
    check_eq("pre_addr", 32'(instr_addr), 32'h3);
    shift_dr = 1'b1; tdi = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre_tdo", 32'(tdo), 32'h1);
    #2 trst_n = 1'b0;
    #1;
    check_eq("mrst_tdo", 32'(tdo), 32'h0);
    check_eq("mrst_addr", 32'(instr_addr), 32'h0);
    check_eq("mrst_data", 32'(instr_data), 32'h0);
    check_eq("mrst_en", 32'(instr_enable), 32'h0);
    shift_dr = 1'b0; tdi = 1'b0;
    tick();
    trst_n = 1'b1;
    tick();
    shift_word(16'h0000, seen);
    check_eq("mrst_sr", 32'(seen), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
